// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared constants and types for the Y86-64 fetch stage:
//               instruction codes, the fetch state encoding and the
//               "no register" specifier.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction codes (upper nibble of byte 0)
  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Register specifier meaning "no register"
  localparam logic [3:0] REG_NONE = 4'hF;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_OUT  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/y86_instr_len.sv
`default_nettype none
// ============================================================================
// Module      : y86_instr_len
// Description : Combinational instruction-format lookup. Maps an icode to
//               its byte length (1/2/9/10), whether byte 1 carries register
//               specifiers, whether a constant is present and the byte index
//               at which the little-endian constant starts.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       has_regs,
  output logic       has_valc,
  output logic [3:0] valc_off
);

  // Format decode; unknown icodes are treated as single-byte instructions
  always_comb begin
    len      = 4'd1;
    has_regs = 1'b0;
    has_valc = 1'b0;
    valc_off = 4'd0;
    case (icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET: begin
        len = 4'd1;
      end
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: begin
        len      = 4'd2;
        has_regs = 1'b1;
      end
      ICODE_JXX, ICODE_CALL: begin
        len      = 4'd9;
        has_valc = 1'b1;
        valc_off = 4'd1;
      end
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ: begin
        len      = 4'd10;
        has_regs = 1'b1;
        has_valc = 1'b1;
        valc_off = 4'd2;
      end
      default: begin
        len = 4'd1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/y86_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : y86_fetch_unit
// Description : Y86-64 sequential fetch stage. Accepts a PC, reads the
//               variable-length instruction one byte per memory request and
//               presents icode/ifun/rA/rB/valC/valP over valid/ready.
//               Optional illegal-icode flagging is enabled by defining
//               FETCH_ICODE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_err,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              imem_error,
  output logic              instr_invalid
);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;

  logic [ADDR_W-1:0] r_cur_pc;
  logic [3:0]        r_idx;
  logic [3:0]        r_icode;
  logic [3:0]        r_ifun;
  logic [3:0]        r_ra;
  logic [3:0]        r_rb;
  logic [63:0]       r_valc;
  logic [ADDR_W-1:0] r_valp;
  logic              r_imem_error;
  logic              r_instr_invalid;

  logic [3:0]        w_icode_sel;
  logic [3:0]        w_len;
  logic              w_has_regs;
  logic              w_has_valc;
  logic [3:0]        w_valc_off;
  logic              w_last;
  logic              w_byte_ok;
  logic [2:0]        w_valc_k;
  logic [3:0]        w_err_len;

  // On byte 0 the format must come from the byte arriving now, not the
  // (still cleared) icode register.
  assign w_icode_sel = (r_idx == 4'd0) ? mem_rdata[7:4] : r_icode;

  y86_instr_len u_instr_len (
    .icode    (w_icode_sel),
    .len      (w_len),
    .has_regs (w_has_regs),
    .has_valc (w_has_valc),
    .valc_off (w_valc_off)
  );

  assign w_last    = ((r_idx + 4'd1) == w_len);
  assign w_byte_ok = (r_state == FETCH_WAIT) && mem_rvalid && !mem_err;
  assign w_valc_k  = 3'(r_idx - w_valc_off);
  // Bytes consumed when a fetch aborts; a fault on byte 0 still advances by 1
  assign w_err_len = (r_idx == 4'd0) ? 4'd1 : r_idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one outstanding byte request at a time
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH_IDLE: if (pc_valid) w_next_state = FETCH_REQ;
      FETCH_REQ:  w_next_state = FETCH_WAIT;
      FETCH_WAIT: begin
        if (mem_rvalid) begin
          w_next_state = (mem_err || w_last) ? FETCH_OUT : FETCH_REQ;
        end
      end
      FETCH_OUT:  if (instr_ready) w_next_state = FETCH_IDLE;
      default:    w_next_state = FETCH_IDLE;
    endcase
  end

  // Handshake and memory-request outputs decoded from the state
  always_comb begin
    pc_ready    = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;
    case (r_state)
      FETCH_IDLE: pc_ready = 1'b1;
      FETCH_REQ: begin
        mem_req  = 1'b1;
        mem_addr = r_cur_pc + ADDR_W'(r_idx);
      end
      FETCH_OUT:  instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Instruction field capture and valP computation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_pc        <= '0;
      r_idx           <= 4'd0;
      r_icode         <= 4'd0;
      r_ifun          <= 4'd0;
      r_ra            <= REG_NONE;
      r_rb            <= REG_NONE;
      r_valc          <= 64'd0;
      r_valp          <= '0;
      r_imem_error    <= 1'b0;
      r_instr_invalid <= 1'b0;
    end else begin
      if ((r_state == FETCH_IDLE) && pc_valid) begin
        r_cur_pc        <= pc_in;
        r_idx           <= 4'd0;
        r_icode         <= 4'd0;
        r_ifun          <= 4'd0;
        r_ra            <= REG_NONE;
        r_rb            <= REG_NONE;
        r_valc          <= 64'd0;
        r_valp          <= '0;
        r_imem_error    <= 1'b0;
        r_instr_invalid <= 1'b0;
      end else if ((r_state == FETCH_WAIT) && mem_rvalid && mem_err) begin
        // Faulting byte is discarded; fields fetched so far are kept
        r_imem_error <= 1'b1;
        r_valp       <= r_cur_pc + ADDR_W'(w_err_len);
      end else if (w_byte_ok) begin
        r_idx <= r_idx + 4'd1;
        if (r_idx == 4'd0) begin
          r_icode <= mem_rdata[7:4];
          r_ifun  <= mem_rdata[3:0];
`ifdef FETCH_ICODE_CHECK_EN
          r_instr_invalid <= (mem_rdata[7:4] > ICODE_POPQ);
`endif
        end else if (w_has_regs && (r_idx == 4'd1)) begin
          r_ra <= mem_rdata[7:4];
          r_rb <= mem_rdata[3:0];
        end else if (w_has_valc && (r_idx >= w_valc_off)) begin
          r_valc[{w_valc_k, 3'b000} +: 8] <= mem_rdata;
        end
        if (w_last) begin
          r_valp <= r_cur_pc + ADDR_W'(w_len);
        end
      end
    end
  end

  assign icode         = r_icode;
  assign ifun          = r_ifun;
  assign rA            = r_ra;
  assign rB            = r_rb;
  assign valC          = r_valc;
  assign valP          = r_valp;
  assign imem_error    = r_imem_error;
  assign instr_invalid = r_instr_invalid;

endmodule
`default_nettype wire

// File: tb/tb_y86_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_fetch_unit
// Description : Self-checking bench for y86_fetch_unit with a byte memory
//               responder (1-cycle latency), a format-table reference model
//               and an every-cycle compare while instr_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_fetch_unit;

  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;
  logic              mem_err;
  logic [3:0]        icode, ifun, rA, rB;
  logic [63:0]       valC;
  logic [ADDR_W-1:0] valP;
  logic              instr_valid;
  logic              instr_ready;
  logic              imem_error;
  logic              instr_invalid;

  y86_fetch_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .imem_error(imem_error), .instr_invalid(instr_invalid)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Memory image and fault injection
  logic [7:0]  mem [logic [63:0]];
  logic [7:0]  prog [$];
  bit          err_en;
  logic [63:0] err_addr;
  int          req_count;

  // Reference expectations for the instruction in flight
  bit          exp_active = 1'b0;
  logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
  logic [63:0] e_valc, e_valp;
  logic        e_err, e_inv;
  int          e_nreq;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Expected fields from the ISA format table and fault position
  task automatic model(input logic [63:0] pc, input int err_idx);
    logic [3:0] ic;
    int len, avail, off;
    e_icode = 4'h0; e_ifun = 4'h0; e_ra = 4'hF; e_rb = 4'hF;
    e_valc = 64'd0; e_err = 1'b0; e_inv = 1'b0;
    ic = prog[0][7:4];
    case (ic)
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h7, 4'h8:             len = 9;
      4'h3, 4'h4, 4'h5:       len = 10;
      default:                len = 1;
    endcase
    if (err_idx >= 0 && err_idx < len) begin
      e_nreq = err_idx + 1;
      avail  = err_idx;
      e_err  = 1'b1;
      e_valp = pc + 64'((err_idx == 0) ? 1 : err_idx);
    end else begin
      e_nreq = len;
      avail  = len;
      e_valp = pc + 64'(len);
    end
    if (avail > 0) begin
      e_icode = ic;
      e_ifun  = prog[0][3:0];
`ifdef FETCH_ICODE_CHECK_EN
      e_inv = (ic > 4'hB);
`endif
    end
    if ((len == 2 || len == 10) && avail > 1) begin
      e_ra = prog[1][7:4];
      e_rb = prog[1][3:0];
    end
    off = (len == 10) ? 2 : 1;
    if (len >= 9) begin
      for (int k = 0; k < 8; k++) begin
        if (off + k < avail) e_valc[8*k +: 8] = prog[off+k];
      end
    end
  endtask

  // Byte memory: answers each request one cycle later
  initial begin
    logic [63:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    mem_err    = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        a = mem_addr;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_err    = err_en && (a == err_addr);
        mem_rdata  = mem_err ? 8'hEE : (mem.exists(a) ? mem[a] : 8'h00);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
      end
    end
  end

  // Request counter
  always @(negedge clk) begin
    if (mem_req) req_count++;
  end

  // Every-cycle compare while an instruction is presented
  always @(negedge clk) begin
    if (rst_n && exp_active && instr_valid) begin
      chk("icode", icode, e_icode);
      chk("ifun", ifun, e_ifun);
      chk("rA", rA, e_ra);
      chk("rB", rB, e_rb);
      chk("valC", valC, e_valc);
      chk("valP", valP, e_valp);
      chk("imem_error", imem_error, e_err);
      chk("instr_invalid", instr_invalid, e_inv);
    end
  end

  task automatic load(input logic [63:0] pc);
    mem.delete();
    for (int i = 0; i < prog.size(); i++) mem[pc + 64'(i)] = prog[i];
  endtask

  task automatic fetch(input logic [63:0] pc, input int err_idx, input int hold);
    int  n;
    bit  got;
    load(pc);
    err_en   = (err_idx >= 0);
    err_addr = pc + 64'(err_idx);
    model(pc, err_idx);
    req_count = 0;
    @(negedge clk);
    chk("pc_ready_idle", pc_ready, 1'b1);
    pc_in    = pc;
    pc_valid = 1'b1;
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
    pc_in    = '0;
    n   = 1;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (instr_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", got ? 64'(n) : 64'd0, 64'(2 * e_nreq + 1));
    exp_active = 1'b1;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    exp_active  = 1'b0;
    chk("out_to_idle", {instr_valid, pc_ready}, 2'b01);
    chk("req_count", req_count, e_nreq);
    err_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pc_in = '0; pc_valid = 1'b0; instr_ready = 1'b0;
    err_en = 1'b0; err_addr = '0; req_count = 0;
    repeat (3) @(negedge clk);
    chk("rst_pc_ready", pc_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_rA", rA, 4'hF);
    chk("rst_valP", valP, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nop
    prog = {8'h10};
    fetch(64'h100, -1, 0);
    chk("nop_valP", valP, 64'h101);
    chk("nop_rB", rB, 4'hF);

    // irmovq $0x0102030405060708, %rdx
    prog = {8'h30, 8'hF2, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    fetch(64'h0, -1, 0);
    chk("irmovq_valC", valC, 64'h0102030405060708);
    chk("irmovq_valP", valP, 64'hA);
    chk("irmovq_rB", rB, 4'h2);

    // jne 0x1000, held for 5 cycles
    prog = {8'h74, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fetch(64'h20, -1, 5);
    chk("jne_ifun", ifun, 4'h4);
    chk("jne_valC", valC, 64'h1000);
    chk("jne_valP", valP, 64'h29);

    // rrmovq with a fault on byte 1
    prog = {8'h20, 8'h12};
    fetch(64'h40, 1, 0);
    chk("err1_imem_error", imem_error, 1'b1);
    chk("err1_valP", valP, 64'h41);
    chk("err1_rA", rA, 4'hF);

    // fault on byte 0
    prog = {8'h30, 8'hF2};
    fetch(64'h80, 0, 1);
    chk("err0_valP", valP, 64'h81);

    // ret at the top of the address space
    prog = {8'h90};
    fetch(64'hFFFF_FFFF_FFFF_FFFF, -1, 0);
    chk("wrap_valP", valP, 64'h0);
    chk("wrap_icode", icode, 4'h9);

    // opq and mrmovq
    prog = {8'h60, 8'h23};
    fetch(64'h200, -1, 2);
    chk("opq_valP", valP, 64'h202);
    prog = {8'h50, 8'h15, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    fetch(64'h500, -1, 0);
    chk("mrmovq_valC", valC, 64'h0123456789ABCDEF);

    // reset asserted mid-fetch of a call
    prog = {8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    load(64'h300);
    req_count = 0;
    @(negedge clk);
    pc_in = 64'h300; pc_valid = 1'b1;
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (req_count >= 3) break;
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    chk("call_icode_pre_rst", icode, 4'h8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc_ready", pc_ready, 1'b1);
    chk("mid_rst_mem_req", mem_req, 1'b0);
    chk("mid_rst_mem_addr", mem_addr, 64'd0);
    chk("mid_rst_icode", icode, 4'h0);
    chk("mid_rst_rA", rA, 4'hF);
    chk("mid_rst_valC", valC, 64'd0);
    chk("mid_rst_valP", valP, 64'd0);
    chk("mid_rst_imem_error", imem_error, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_instr_valid", instr_valid, 1'b0);

    // icode beyond POPQ
    prog = {8'hC0};
    fetch(64'h600, -1, 0);
    chk("c0_valP", valP, 64'h601);
`ifdef FETCH_ICODE_CHECK_EN
    chk("c0_invalid", instr_invalid, 1'b1);
`else
    chk("c0_invalid", instr_invalid, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y86_fetch_unit.md
# y86_fetch_unit

Sequential instruction fetch stage for the Y86-64 processor. Consumes the program counter produced by the PC-update stage, reads the variable-length instruction (1, 2, 9 or 10 bytes) from a byte-wide instruction memory, one byte per request, and presents the decoded fields icode, ifun, rA, rB, valC and valP to decode/execute over a valid/ready handshake.

## Interface
- ADDR_W, 64, width of PC, memory address and valP
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_in  in  ADDR_W  address of next instruction
- pc_valid  in  1  pc_in valid; accepted when pc_ready=1
- pc_ready  out  1  high only in IDLE
- mem_req  out  1  single-cycle byte read request
- mem_addr  out  ADDR_W  byte address, valid with mem_req
- mem_rvalid  in  1  read data returned, at least 1 cycle after mem_req
- mem_rdata  in  8  returned byte
- mem_err  in  1  address error, sampled with mem_rvalid
- icode  out  4  instruction code
- ifun  out  4  function code
- rA, rB  out  4 each  register specifiers; 4'hF when no register byte
- valC  out  64  constant, little-endian assembled; 0 when none
- valP  out  ADDR_W  pc + instruction length
- instr_valid  out  1  fields valid; held until instr_ready
- instr_ready  in  1  downstream accepts
- imem_error  out  1  mem_err seen during this instruction
- instr_invalid  out  1  illegal icode (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, OUT.
- IDLE: pc_ready=1; on pc_valid latch pc_in into cur_pc, clear byte index and fields, go to REQ.
- REQ: mem_req=1, mem_addr=cur_pc+idx; go to WAIT.
- WAIT: on mem_rvalid store byte idx: byte 0 -> {icode,ifun}; byte 1 of register formats -> {rA,rB}; constant bytes -> valC[8k+7:8k]. idx++. If mem_err or idx+1 == length -> OUT, else REQ.
- Lengths: icode 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9 (valC from bytes 1..8); 3,4,5 -> 10 (regs byte 1, valC bytes 2..9).
- valP = cur_pc + length, modulo 2^ADDR_W (wraps).
- mem_err: imem_error=1, remaining bytes not fetched, unfetched fields keep defaults, valP = cur_pc + length-so-far (1 if on byte 0).
- OUT: instr_valid=1; fields stable; when instr_ready go to IDLE. pc_valid ignored outside IDLE.

## Timing
- Reset (async, any state incl. mid-fetch or OUT): state IDLE, pc_ready=1, mem_req=0, mem_addr=0, instr_valid=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0, imem_error=0, instr_invalid=0. Late mem_rvalid after reset is ignored in IDLE.
- One outstanding request; next mem_req no earlier than cycle after mem_rvalid.
- With 1-cycle memory: N-byte instruction accepted at cycle 0 gives instr_valid at cycle 2N+1 (nop: 3, jXX: 19, irmovq: 21).
- Back-to-back: OUT with instr_ready -> IDLE next cycle; minimum one bubble between instructions.

## Configuration
- FETCH_ICODE_CHECK_EN defined: icode > 4'hB sets instr_invalid=1, length 1, go to OUT after byte 0.
- Undefined: no check, instr_invalid tied 0, icode > 4'hB treated as length 1 without flag.

## Structure
- y86_pkg: ICODE_* constants (HALT..POPQ), fetch state enum, REG_NONE=4'hF.
- Sub-module y86_instr_len: combinational icode -> length (1/2/9/10), has_regs, has_valC, valC byte offset.

## Test plan
- nop at pc=0x100, bytes {10} -> icode=1, rA=rB=F, valC=0, valP=0x101, instr_valid at cycle 3.
- irmovq at 0x0, bytes {30 F2 08 07 06 05 04 03 02 01} -> icode=3, rA=F, rB=2, valC=0x0102030405060708, valP=0xA.
- jne at 0x20, bytes {74 00 10 00 00 00 00 00 00} -> icode=7, ifun=4, valC=0x1000, valP=0x29; hold instr_ready=0 5 cycles -> fields stable.
- mem_err on byte 1 of rrmovq at 0x40 -> imem_error=1, icode=2, rA=rB=F, valP=0x41; no further mem_req.
- pc=0xFFFF_FFFF_FFFF_FFFF, byte {90} -> icode=9, valP=0 (wrap).
- rst_n low during WAIT of call -> all outputs to reset values same cycle; following pc_valid fetches normally; with FETCH_ICODE_CHECK_EN byte {C0} -> instr_invalid=1, valP=pc+1.
